stream_responder: RTL and testbench
===================================

# stream_responder

Top-level streaming responder serving per-PE stream requests. Arbitrates round-robin among `NUM_PE` PE controllers, reads the requested filter group (and, for layer 0, the input activation block) from the on-chip weight/activation buffer, and returns them as response beats. Completes each request with one-cycle filter/input finish pulses. Sits between the PE array's request bus and the shared buffer.

## Interface
Parameters:
- `NUM_PE`, 4: number of requesting PEs; `PE_W = $clog2(NUM_PE)`.
- `F`, 4: data elements per beat.
- `DATA_W`, 16: element width.
- `K_W`, 6: filter-group index width.
- `LAYER_W`, 3: conv layer number width.
- `ADDR_W`, 12: buffer address width; one address holds one beat.
- `BEAT_W`, 10: beat count width.

Ports:
- `clk` in 1: clock; single clock domain.
- `rst` in 1: reset; synchronous, active-low (`rst==0` resets on the `clk` edge).
- `req_filter_valid` in NUM_PE: per-PE filter request, held until finish.
- `req_input_valid` in NUM_PE: per-PE input request, honoured only with `req_filter_valid`.
- `req_filter_k` in NUM_PE*K_W: per-PE requested filter group.
- `req_layer` in NUM_PE*LAYER_W: per-PE conv layer number.
- `filter_beats` in BEAT_W: beats per filter group, static while not IDLE.
- `input_beats` in BEAT_W: beats per input block, static while not IDLE.
- `filter_base`, `input_base` in ADDR_W each: region base addresses.
- `mem_rd_en` out 1, `mem_rd_addr` out ADDR_W: buffer read; data returns 1 cycle later.
- `mem_rd_data` in F*DATA_W: read data.
- `resp_valid` out 1, `resp_ready` in 1: response handshake.
- `resp_pe_id` out PE_W, `resp_type` out 1 (0 filter, 1 input), `resp_data` out F*DATA_W, `resp_last` out 1.
- `stream_filter_finish` out NUM_PE, `stream_input_finish` out NUM_PE: one-cycle completion pulses.

## Operation
- FSM: IDLE, ARB, RD_FILTER, RD_INPUT, DONE.
- IDLE -> ARB on the first cycle with `rst==1`.
- ARB: round-robin grant among PEs with `req_filter_valid`. Priority starts at `last_served+1 mod NUM_PE`; `last_served` resets to NUM_PE-1, so PE0 has first priority. Latch `pe`, `k`, and `do_input = req_input_valid[pe] && req_layer[pe]==0`. Go to RD_FILTER, or straight to DONE if `filter_beats==0`. No requests: stay in ARB.
- RD_FILTER: read beats 0..filter_beats-1 at `filter_base + k*filter_beats + beat`. Addition and multiply are truncated to ADDR_W and wrap modulo 2^ADDR_W. After the last beat is issued: RD_INPUT if `do_input && input_beats!=0`, else DONE once all beats are accepted.
- RD_INPUT: read `input_base + beat`, `resp_type=1`. Go to DONE once the last beat is accepted.
- DONE (one cycle): pulse `stream_filter_finish[pe]`. If `do_input`, also pulse `stream_input_finish[pe]` in the same cycle, including when `input_beats==0`. Set `last_served=pe`, then go to ARB.
- `resp_last` is 1 on the final beat of each type.
- Output path: 2-entry skid FIFO. `mem_rd_en` is asserted only when FIFO occupancy plus in-flight reads is less than 2, so no beat is lost under `resp_ready` backpressure.
- `resp_*` fields are stable while `resp_valid && !resp_ready`.
- The just-served PE is masked during the first ARB cycle after DONE; its request drops one cycle after its finish pulse.

## Timing
- Reset values: all outputs 0. FSM goes to IDLE, FIFO is flushed, in-flight reads are discarded, `last_served` is NUM_PE-1.
- Reset asserted mid-stream aborts the request with no finish pulse.
- Latency with `resp_ready=1`: grant in ARB at cycle T, first `mem_rd_en` at T+1, first `resp_valid` at T+2, then one beat per cycle.
- The last beat is accepted at T+1+N, DONE is at T+2+N, and the next ARB is at T+3+N.
- Zero-beat filter: ARB at T, DONE at T+1.
- Simultaneous requests: exactly one grant per ARB cycle; the others wait with no starvation.

## Test plan
- Single request: PE0 requests k=2, `filter_beats=3`, `filter_base=0x100`, layer 1. Expect reads at 0x106, 0x107, 0x108; 3 beats with `resp_type=0` and `resp_last` on the third; one `stream_filter_finish[0]` pulse; no input finish.
- Layer 0 with input: PE1 requests k=0, `filter_beats=2`, `input_beats=4`, `input_base=0x200`. Expect 2 filter beats then 4 input beats at 0x200..0x203, then `stream_filter_finish[1]` and `stream_input_finish[1]` high in the same cycle.
- Round-robin: PEs 0, 2 and 3 request simultaneously and re-request after each finish. Expect service order 0, 2, 3, 0, …
- Backpressure: `resp_ready` toggles 1,0,0,1 repeatedly during a 5-beat stream. Expect data order and values intact, no duplicate or lost beats, and `resp_data` stable while stalled.
- Boundaries: `filter_beats=0` gives a finish 1 cycle after grant with no reads. `filter_base=0xFFE`, k=0, 3 beats reads 0xFFE, 0xFFF, 0x000.
- Reset mid-op: drive `rst=0` during beat 2. Expect all outputs 0 next cycle, no finish pulse, and a clean restart serving PE0.

Source files
------------

// File: rtl/stream_responder.sv
// stream_responder: round-robin streaming responder between the PE request bus
// and the shared weight/activation buffer.
//
// For each granted PE it streams one filter group (and, for layer 0 with an input
// request, the input activation block) as response beats, then pulses the finish
// outputs for one cycle.
//
// Ports
//   clk, rst                  clock; synchronous active-low reset
//   req_*                     per-PE request valid / filter group / layer
//   filter_beats, input_beats beats per filter group / input block
//   filter_base, input_base   buffer region base addresses
//   mem_rd_*                  buffer read port (data one cycle after mem_rd_en)
//   resp_*                    response beat stream, valid/ready handshake
//   stream_*_finish           one-cycle per-PE completion pulses
module stream_responder #(
    parameter int unsigned NUM_PE  = 4,
    parameter int unsigned F       = 4,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned K_W     = 6,
    parameter int unsigned LAYER_W = 3,
    parameter int unsigned ADDR_W  = 12,
    parameter int unsigned BEAT_W  = 10,
    localparam int unsigned PE_W   = (NUM_PE > 1) ? $clog2(NUM_PE) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_PE-1:0]         req_filter_valid,
    input  logic [NUM_PE-1:0]         req_input_valid,
    input  logic [NUM_PE*K_W-1:0]     req_filter_k,
    input  logic [NUM_PE*LAYER_W-1:0] req_layer,
    input  logic [BEAT_W-1:0]         filter_beats,
    input  logic [BEAT_W-1:0]         input_beats,
    input  logic [ADDR_W-1:0]         filter_base,
    input  logic [ADDR_W-1:0]         input_base,
    output logic                      mem_rd_en,
    output logic [ADDR_W-1:0]         mem_rd_addr,
    input  logic [F*DATA_W-1:0]       mem_rd_data,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [PE_W-1:0]           resp_pe_id,
    output logic                      resp_type,
    output logic [F*DATA_W-1:0]       resp_data,
    output logic                      resp_last,
    output logic [NUM_PE-1:0]         stream_filter_finish,
    output logic [NUM_PE-1:0]         stream_input_finish
);

    localparam int unsigned BeatDataW = F * DATA_W;

    typedef enum logic [2:0] {StIdle, StArb, StRdFilter, StRdInput, StDone} state_e;

    state_e              state_q, state_d;
    logic [PE_W-1:0]     last_served_q, last_served_d;
    logic [PE_W-1:0]     pe_q, pe_d;
    logic [K_W-1:0]      k_q, k_d;
    logic                do_input_q, do_input_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic                mask_q;

    // Read issued last cycle; its data is on mem_rd_data this cycle.
    logic                inflight_q, inflight_type_q, inflight_last_q;

    logic [BeatDataW-1:0] fifo_data_q [2];
    logic                 fifo_type_q [2];
    logic                 fifo_last_q [2];
    logic                 wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [1:0]           count_q, count_d;

    // Arbitration
    logic [NUM_PE-1:0]  req_eff;
    logic               gnt_valid;
    logic [PE_W-1:0]    gnt_idx;
    logic [PE_W-1:0]    cand_idx;
    int                 cand;
    logic [K_W-1:0]     gnt_k;
    logic [LAYER_W-1:0] gnt_layer;

    always_comb begin
        req_eff   = req_filter_valid;
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        // The PE just finished still holds its request for one more cycle.
        if (mask_q) req_eff[last_served_q] = 1'b0;
        for (int i = 1; i <= int'(NUM_PE); i++) begin
            cand     = (int'(last_served_q) + i) % int'(NUM_PE);
            cand_idx = PE_W'(cand);
            if (!gnt_valid && req_eff[cand_idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand_idx;
            end
        end
    end

    assign gnt_k     = req_filter_k[int'(gnt_idx)*K_W +: K_W];
    assign gnt_layer = req_layer[int'(gnt_idx)*LAYER_W +: LAYER_W];

    // Read issue
    logic [BEAT_W-1:0] cur_total;
    logic [1:0]        outstanding;
    logic              rd_state, issue, last_issue, go_input;
    logic [ADDR_W-1:0] k_off, beat_off, rd_addr;

    assign cur_total   = (state_q == StRdInput) ? input_beats : filter_beats;
    assign outstanding = count_q + {1'b0, inflight_q};
    assign rd_state    = (state_q == StRdFilter) || (state_q == StRdInput);
    // Reads are throttled so every issued beat has a FIFO slot under backpressure.
    assign issue       = rd_state && (beat_q < cur_total) && (outstanding < 2'd2);
    assign last_issue  = (beat_q + BEAT_W'(1)) == cur_total;
    assign go_input    = do_input_q && (input_beats != '0);

    assign k_off    = ADDR_W'(k_q) * ADDR_W'(filter_beats);
    assign beat_off = ADDR_W'(beat_q);
    assign rd_addr  = (state_q == StRdInput) ? input_base + beat_off
                                             : filter_base + k_off + beat_off;

    assign mem_rd_en   = issue;
    assign mem_rd_addr = issue ? rd_addr : '0;

    // Response path: FIFO head, or the returning read when the FIFO is empty.
    logic                 fire, push, pop, last_accept;
    logic [BeatDataW-1:0] head_data;
    logic                 head_type, head_last;

    always_comb begin
        head_data = mem_rd_data;
        head_type = inflight_type_q;
        head_last = inflight_last_q;
        if (count_q != '0) begin
            head_data = fifo_data_q[rd_ptr_q];
            head_type = fifo_type_q[rd_ptr_q];
            head_last = fifo_last_q[rd_ptr_q];
        end
    end

    assign resp_valid  = (count_q != '0) || inflight_q;
    assign fire        = resp_valid && resp_ready;
    assign push        = inflight_q && !((count_q == '0) && resp_ready);
    assign pop         = fire && (count_q != '0);
    assign last_accept = fire && (outstanding == 2'd1);

    assign resp_data  = resp_valid ? head_data : '0;
    assign resp_type  = resp_valid ? head_type : 1'b0;
    assign resp_last  = resp_valid ? head_last : 1'b0;
    assign resp_pe_id = resp_valid ? pe_q : '0;

    assign stream_filter_finish = (state_q == StDone) ? (NUM_PE'(1) << pe_q) : '0;
    assign stream_input_finish  = (state_q == StDone && do_input_q) ? (NUM_PE'(1) << pe_q) : '0;

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) wr_ptr_d = ~wr_ptr_q;
        if (pop)  rd_ptr_d = ~rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // FSM next state
    always_comb begin
        state_d       = state_q;
        last_served_d = last_served_q;
        pe_d          = pe_q;
        k_d           = k_q;
        do_input_d    = do_input_q;
        beat_d        = beat_q;
        unique case (state_q)
            StIdle: state_d = StArb;
            StArb: begin
                if (gnt_valid) begin
                    pe_d       = gnt_idx;
                    k_d        = gnt_k;
                    do_input_d = req_input_valid[gnt_idx] && (gnt_layer == '0);
                    beat_d     = '0;
                    state_d    = (filter_beats == '0) ? StDone : StRdFilter;
                end
            end
            StRdFilter: begin
                if (issue) begin
                    beat_d = beat_q + BEAT_W'(1);
                    // Input reads follow the last filter read without a bubble.
                    if (last_issue && go_input) begin
                        beat_d  = '0;
                        state_d = StRdInput;
                    end
                end
                if (beat_q == cur_total && last_accept) state_d = StDone;
            end
            StRdInput: begin
                if (issue) beat_d = beat_q + BEAT_W'(1);
                if (beat_q == cur_total && last_accept) state_d = StDone;
            end
            StDone: begin
                last_served_d = pe_q;
                state_d       = StArb;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q         <= StIdle;
            last_served_q   <= PE_W'(NUM_PE - 1);
            pe_q            <= '0;
            k_q             <= '0;
            do_input_q      <= 1'b0;
            beat_q          <= '0;
            mask_q          <= 1'b0;
            inflight_q      <= 1'b0;
            inflight_type_q <= 1'b0;
            inflight_last_q <= 1'b0;
            wr_ptr_q        <= 1'b0;
            rd_ptr_q        <= 1'b0;
            count_q         <= '0;
            for (int i = 0; i < 2; i++) begin
                fifo_data_q[i] <= '0;
                fifo_type_q[i] <= 1'b0;
                fifo_last_q[i] <= 1'b0;
            end
        end else begin
            state_q         <= state_d;
            last_served_q   <= last_served_d;
            pe_q            <= pe_d;
            k_q             <= k_d;
            do_input_q      <= do_input_d;
            beat_q          <= beat_d;
            mask_q          <= (state_q == StDone);
            inflight_q      <= issue;
            inflight_type_q <= (state_q == StRdInput);
            inflight_last_q <= last_issue;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
            if (push) begin
                fifo_data_q[wr_ptr_q] <= mem_rd_data;
                fifo_type_q[wr_ptr_q] <= inflight_type_q;
                fifo_last_q[wr_ptr_q] <= inflight_last_q;
            end
        end
    end

endmodule

// File: tb/tb_stream_responder.sv
// Self-checking bench for stream_responder: directed scenarios with hand-computed
// read addresses, beat contents, finish order and finish timing.
module tb_stream_responder;
    localparam int NUM_PE = 4, F = 4, DATA_W = 16, K_W = 6, LAYER_W = 3;
    localparam int ADDR_W = 12, BEAT_W = 10, PE_W = 2, DW = F * DATA_W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                      rst;
    logic [NUM_PE-1:0]         req_filter_valid, req_input_valid;
    logic [NUM_PE*K_W-1:0]     req_filter_k;
    logic [NUM_PE*LAYER_W-1:0] req_layer;
    logic [BEAT_W-1:0]         filter_beats, input_beats;
    logic [ADDR_W-1:0]         filter_base, input_base;
    logic                      mem_rd_en;
    logic [ADDR_W-1:0]         mem_rd_addr;
    logic [DW-1:0]             mem_rd_data = '0;
    logic                      resp_valid, resp_ready;
    logic [PE_W-1:0]           resp_pe_id;
    logic                      resp_type, resp_last;
    logic [DW-1:0]             resp_data;
    logic [NUM_PE-1:0]         stream_filter_finish, stream_input_finish;

    stream_responder #(
        .NUM_PE(NUM_PE), .F(F), .DATA_W(DATA_W), .K_W(K_W), .LAYER_W(LAYER_W),
        .ADDR_W(ADDR_W), .BEAT_W(BEAT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .req_filter_valid(req_filter_valid), .req_input_valid(req_input_valid),
        .req_filter_k(req_filter_k), .req_layer(req_layer),
        .filter_beats(filter_beats), .input_beats(input_beats),
        .filter_base(filter_base), .input_base(input_base),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_pe_id(resp_pe_id),
        .resp_type(resp_type), .resp_data(resp_data), .resp_last(resp_last),
        .stream_filter_finish(stream_filter_finish),
        .stream_input_finish(stream_input_finish)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Buffer content: element e of address a is {a, e}.
    function automatic logic [DW-1:0] word_of(input logic [ADDR_W-1:0] a);
        logic [DW-1:0] w;
        for (int e = 0; e < F; e++) w[e*DATA_W +: DATA_W] = {a, 4'(e)};
        return w;
    endfunction

    always @(posedge clk) if (mem_rd_en) mem_rd_data <= word_of(mem_rd_addr);

    // Observation log
    logic [ADDR_W-1:0] rd_q[$];
    int                rd_cyc[$];
    logic [DW-1:0]     bt_data[$];
    logic              bt_type[$], bt_last[$];
    logic [PE_W-1:0]   bt_pe[$];
    int                fin_pe[$], fin_cyc[$];
    logic              fin_in[$];
    int                stall_cnt = 0, stall_viol = 0, stray_in = 0;
    logic              prev_stall = 1'b0, prev_type = 1'b0, prev_last = 1'b0;
    logic [DW-1:0]     prev_data = '0;
    logic [PE_W-1:0]   prev_pe = '0;

    always @(negedge clk) begin
        if (mem_rd_en) begin
            rd_q.push_back(mem_rd_addr);
            rd_cyc.push_back(cyc);
        end
        if (resp_valid && resp_ready) begin
            bt_data.push_back(resp_data);
            bt_type.push_back(resp_type);
            bt_last.push_back(resp_last);
            bt_pe.push_back(resp_pe_id);
        end
        if (prev_stall && rst && (!resp_valid || resp_data !== prev_data ||
            resp_type !== prev_type || resp_last !== prev_last || resp_pe_id !== prev_pe))
            stall_viol++;
        prev_stall = resp_valid && !resp_ready && rst;
        if (prev_stall) stall_cnt++;
        prev_data = resp_data;
        prev_type = resp_type;
        prev_last = resp_last;
        prev_pe   = resp_pe_id;
        for (int p = 0; p < NUM_PE; p++) begin
            if (stream_filter_finish[p]) begin
                fin_pe.push_back(p);
                fin_in.push_back(stream_input_finish[p]);
                fin_cyc.push_back(cyc);
            end else if (stream_input_finish[p]) begin
                stray_in++;
            end
        end
    end

    // Request handling: drop a request the cycle after its finish, optionally re-raise.
    int  fin_handled = 0;
    bit  pend_rr [NUM_PE];
    int  rereq [NUM_PE];
    bit  bp_on = 1'b0;
    int  bp_idx = 0;
    bit  bp_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    task automatic cycle();
        int p;
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_PE; i++) begin
            if (pend_rr[i]) begin
                req_filter_valid[i] = 1'b1;
                pend_rr[i] = 1'b0;
            end
        end
        while (fin_handled < fin_pe.size()) begin
            p = fin_pe[fin_handled];
            fin_handled++;
            req_filter_valid[p] = 1'b0;
            req_input_valid[p]  = 1'b0;
            if (rereq[p] > 0) begin
                rereq[p]--;
                pend_rr[p] = 1'b1;
            end
        end
        if (bp_on) begin
            resp_ready = bp_pat[bp_idx % 4];
            bp_idx++;
        end
    endtask

    task automatic wait_fins(input int n, input int budget, output bit ok);
        int c = 0;
        while (fin_pe.size() < n && c < budget) begin
            cycle();
            c++;
        end
        ok = (fin_pe.size() >= n);
    endtask

    task automatic set_req(input int p, input int k, input int layer, input bit inp);
        req_filter_k[p*K_W +: K_W]         = K_W'(k);
        req_layer[p*LAYER_W +: LAYER_W]    = LAYER_W'(layer);
        req_input_valid[p]                 = inp;
        req_filter_valid[p]                = 1'b1;
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        req_filter_valid = '0;
        req_input_valid  = '0;
        repeat (3) cycle();
        rst = 1'b1;
        repeat (3) cycle();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        req_filter_valid = '1;
        repeat (2) cycle();
        @(negedge clk);
        checks++;
        if ({mem_rd_en, mem_rd_addr} !== '0) begin
            errors++;
            $display("FAIL reset_mem: got en=%b addr=%h expected 0", mem_rd_en, mem_rd_addr);
        end
        checks++;
        if ({resp_valid, resp_type, resp_last, resp_pe_id, resp_data} !== '0) begin
            errors++;
            $display("FAIL reset_resp: got v=%b t=%b l=%b pe=%0d d=%h expected 0",
                     resp_valid, resp_type, resp_last, resp_pe_id, resp_data);
        end
        checks++;
        if ({stream_filter_finish, stream_input_finish} !== '0) begin
            errors++;
            $display("FAIL reset_fin: got %b %b expected 0",
                     stream_filter_finish, stream_input_finish);
        end
        apply_reset();
    endtask

    task automatic test_single();
        int start, rb, bb, fb;
        bit ok;
        logic [ADDR_W-1:0] ea [3] = '{12'h106, 12'h107, 12'h108};
        logic [ADDR_W-1:0] ga;
        logic [PE_W+2+DW-1:0] gb, eb;
        cycle();
        filter_beats = 10'd3; filter_base = 12'h100; input_beats = 10'd0;
        rb = rd_q.size(); bb = bt_data.size(); fb = fin_pe.size();
        set_req(0, 2, 1, 1'b1);
        start = cyc;
        wait_fins(fb + 1, 40, ok);
        repeat (2) cycle();
        checks++;
        if (!ok) begin errors++; $display("FAIL single_timeout: got no finish expected one"); end
        checks++;
        if (rd_q.size() - rb != 3) begin
            errors++; $display("FAIL single_rd_count: got %0d expected 3", rd_q.size() - rb);
        end
        for (int i = 0; i < 3; i++) begin
            ga = (rb + i < rd_q.size()) ? rd_q[rb+i] : 'x;
            checks++;
            if (ga !== ea[i]) begin
                errors++; $display("FAIL single_rd_addr[%0d]: got %h expected %h", i, ga, ea[i]);
            end
        end
        checks++;
        if (rd_q.size() <= rb || rd_cyc[rb] != start + 1) begin
            errors++; $display("FAIL single_first_rd_cycle: got %0d expected %0d",
                               (rd_q.size() > rb) ? rd_cyc[rb] : -1, start + 1);
        end
        checks++;
        if (bt_data.size() - bb != 3) begin
            errors++; $display("FAIL single_beat_count: got %0d expected 3", bt_data.size() - bb);
        end
        for (int i = 0; i < 3; i++) begin
            eb = {2'd0, 1'b0, (i == 2), word_of(ea[i])};
            gb = (bb + i < bt_data.size()) ?
                 {bt_pe[bb+i], bt_type[bb+i], bt_last[bb+i], bt_data[bb+i]} : 'x;
            checks++;
            if (gb !== eb) begin
                errors++; $display("FAIL single_beat[%0d]: got %h expected %h", i, gb, eb);
            end
        end
        checks++;
        if (fin_pe.size() != fb + 1 || fin_pe[fb] != 0 || fin_in[fb] !== 1'b0 ||
            fin_cyc[fb] != start + 5) begin
            errors++;
            $display("FAIL single_finish: got n=%0d pe=%0d in=%b cyc=%0d expected n=1 pe=0 in=0 cyc=%0d",
                     fin_pe.size() - fb, (fin_pe.size() > fb) ? fin_pe[fb] : -1,
                     (fin_pe.size() > fb) ? fin_in[fb] : 1'bx,
                     (fin_pe.size() > fb) ? fin_cyc[fb] : -1, start + 5);
        end
    endtask

    task automatic test_layer0_input();
        int start, rb, bb, fb;
        bit ok;
        logic [ADDR_W-1:0] ea [6] = '{12'h100, 12'h101, 12'h200, 12'h201, 12'h202, 12'h203};
        logic [PE_W+2+DW-1:0] gb, eb;
        cycle();
        filter_beats = 10'd2; filter_base = 12'h100; input_beats = 10'd4; input_base = 12'h200;
        rb = rd_q.size(); bb = bt_data.size(); fb = fin_pe.size();
        set_req(1, 0, 0, 1'b1);
        start = cyc;
        wait_fins(fb + 1, 40, ok);
        repeat (2) cycle();
        checks++;
        if (rd_q.size() - rb != 6 || bt_data.size() - bb != 6) begin
            errors++; $display("FAIL l0_counts: got rd=%0d beats=%0d expected 6 and 6",
                               rd_q.size() - rb, bt_data.size() - bb);
        end
        for (int i = 0; i < 6; i++) begin
            eb = {2'd1, (i >= 2), (i == 1 || i == 5), word_of(ea[i])};
            gb = (bb + i < bt_data.size()) ?
                 {bt_pe[bb+i], bt_type[bb+i], bt_last[bb+i], bt_data[bb+i]} : 'x;
            checks++;
            if (gb !== eb) begin
                errors++; $display("FAIL l0_beat[%0d]: got %h expected %h", i, gb, eb);
            end
        end
        checks++;
        if (!ok || fin_pe[fb] != 1 || fin_in[fb] !== 1'b1 || fin_cyc[fb] != start + 8) begin
            errors++;
            $display("FAIL l0_finish: got ok=%b pe=%0d in=%b cyc=%0d expected pe=1 in=1 cyc=%0d",
                     ok, ok ? fin_pe[fb] : -1, ok ? fin_in[fb] : 1'bx,
                     ok ? fin_cyc[fb] : -1, start + 8);
        end
    endtask

    task automatic test_round_robin();
        int fb;
        bit ok;
        int exp_order [6] = '{0, 2, 3, 0, 2, 3};
        int got;
        apply_reset();
        filter_beats = 10'd1; filter_base = 12'h000;
        fb = fin_pe.size();
        rereq[0] = 1; rereq[2] = 1; rereq[3] = 1;
        set_req(0, 0, 1, 1'b0);
        set_req(2, 1, 1, 1'b0);
        set_req(3, 2, 1, 1'b0);
        wait_fins(fb + 6, 200, ok);
        repeat (3) cycle();
        checks++;
        if (!ok) begin errors++; $display("FAIL rr_timeout: got %0d finishes expected 6",
                                          fin_pe.size() - fb); end
        for (int i = 0; i < 6; i++) begin
            got = (fb + i < fin_pe.size()) ? fin_pe[fb+i] : -1;
            checks++;
            if (got != exp_order[i]) begin
                errors++; $display("FAIL rr_order[%0d]: got pe %0d expected pe %0d",
                                   i, got, exp_order[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int rb, bb, fb, sc, sv;
        bit ok;
        logic [PE_W+2+DW-1:0] gb, eb;
        cycle();
        filter_beats = 10'd5; filter_base = 12'h000;
        rb = rd_q.size(); bb = bt_data.size(); fb = fin_pe.size();
        sc = stall_cnt; sv = stall_viol;
        resp_ready = bp_pat[0];
        bp_idx = 1;
        bp_on = 1'b1;
        set_req(2, 1, 2, 1'b0);
        wait_fins(fb + 1, 80, ok);
        bp_on = 1'b0;
        resp_ready = 1'b1;
        repeat (2) cycle();
        checks++;
        if (!ok || rd_q.size() - rb != 5 || bt_data.size() - bb != 5) begin
            errors++; $display("FAIL bp_counts: got ok=%b rd=%0d beats=%0d expected 5 and 5",
                               ok, rd_q.size() - rb, bt_data.size() - bb);
        end
        for (int i = 0; i < 5; i++) begin
            eb = {2'd2, 1'b0, (i == 4), word_of(ADDR_W'(5 + i))};
            gb = (bb + i < bt_data.size()) ?
                 {bt_pe[bb+i], bt_type[bb+i], bt_last[bb+i], bt_data[bb+i]} : 'x;
            checks++;
            if (gb !== eb) begin
                errors++; $display("FAIL bp_beat[%0d]: got %h expected %h", i, gb, eb);
            end
        end
        checks++;
        if (stall_cnt == sc || stall_viol != sv) begin
            errors++; $display("FAIL bp_stall: got stalls=%0d unstable=%0d expected >0 and 0",
                               stall_cnt - sc, stall_viol - sv);
        end
    endtask

    task automatic test_zero_beats();
        int start, rb, bb, fb;
        bit ok;
        cycle();
        filter_beats = 10'd0; input_beats = 10'd0;
        rb = rd_q.size(); bb = bt_data.size(); fb = fin_pe.size();
        set_req(3, 5, 0, 1'b1);
        start = cyc;
        wait_fins(fb + 1, 20, ok);
        repeat (2) cycle();
        checks++;
        if (!ok || fin_pe[fb] != 3 || fin_in[fb] !== 1'b1 || fin_cyc[fb] != start + 1) begin
            errors++;
            $display("FAIL zero_finish: got ok=%b pe=%0d in=%b cyc=%0d expected pe=3 in=1 cyc=%0d",
                     ok, ok ? fin_pe[fb] : -1, ok ? fin_in[fb] : 1'bx,
                     ok ? fin_cyc[fb] : -1, start + 1);
        end
        checks++;
        if (rd_q.size() != rb || bt_data.size() != bb || stray_in != 0) begin
            errors++; $display("FAIL zero_traffic: got rd=%0d beats=%0d stray=%0d expected 0",
                               rd_q.size() - rb, bt_data.size() - bb, stray_in);
        end
    endtask

    task automatic test_wrap();
        int rb, fb;
        bit ok;
        logic [ADDR_W-1:0] ea [3] = '{12'hFFE, 12'hFFF, 12'h000};
        logic [ADDR_W-1:0] ga;
        cycle();
        filter_beats = 10'd3; filter_base = 12'hFFE;
        rb = rd_q.size(); fb = fin_pe.size();
        set_req(0, 0, 1, 1'b0);
        wait_fins(fb + 1, 40, ok);
        repeat (2) cycle();
        for (int i = 0; i < 3; i++) begin
            ga = (rb + i < rd_q.size()) ? rd_q[rb+i] : 'x;
            checks++;
            if (!ok || ga !== ea[i]) begin
                errors++; $display("FAIL wrap_rd[%0d]: got %h expected %h", i, ga, ea[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int bb, fb, rb, c, got0, got1;
        bit ok;
        logic [ADDR_W-1:0] ga;
        cycle();
        filter_beats = 10'd5; filter_base = 12'h300;
        bb = bt_data.size(); fb = fin_pe.size();
        set_req(1, 0, 1, 1'b0);
        c = 0;
        while (bt_data.size() < bb + 2 && c < 30) begin cycle(); c++; end
        checks++;
        if (bt_data.size() < bb + 2) begin
            errors++; $display("FAIL mid_reach_beat2: got %0d beats expected 2", bt_data.size() - bb);
        end
        rst = 1'b0;
        cycle();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({mem_rd_en, mem_rd_addr, resp_valid, resp_type, resp_last, resp_pe_id, resp_data,
             stream_filter_finish, stream_input_finish} !== '0) begin
            errors++; $display("FAIL mid_outputs_zero: got en=%b v=%b d=%h fin=%b expected 0",
                               mem_rd_en, resp_valid, resp_data, stream_filter_finish);
        end
        rb = rd_q.size();
        cycle();
        set_req(0, 3, 1, 1'b0);
        checks++;
        if (fin_pe.size() != fb) begin
            errors++; $display("FAIL mid_no_finish: got %0d finishes expected 0", fin_pe.size() - fb);
        end
        wait_fins(fb + 2, 80, ok);
        repeat (2) cycle();
        got0 = (fin_pe.size() > fb) ? fin_pe[fb] : -1;
        got1 = (fin_pe.size() > fb + 1) ? fin_pe[fb+1] : -1;
        checks++;
        if (!ok || got0 != 0 || got1 != 1) begin
            errors++; $display("FAIL mid_restart_order: got %0d,%0d expected 0,1", got0, got1);
        end
        ga = (rd_q.size() > rb) ? rd_q[rb] : 'x;
        checks++;
        if (ga !== 12'h30F) begin
            errors++; $display("FAIL mid_restart_addr: got %h expected 30f", ga);
        end
    endtask

    initial begin
        rst = 1'b0;
        req_filter_valid = '0; req_input_valid = '0;
        req_filter_k = '0; req_layer = '0;
        filter_beats = '0; input_beats = '0; filter_base = '0; input_base = '0;
        resp_ready = 1'b1;
        for (int i = 0; i < NUM_PE; i++) begin pend_rr[i] = 1'b0; rereq[i] = 0; end
        test_reset();
        test_single();
        repeat (3) cycle();
        test_layer0_input();
        repeat (3) cycle();
        test_round_robin();
        repeat (3) cycle();
        test_backpressure();
        repeat (3) cycle();
        test_zero_beats();
        repeat (3) cycle();
        test_wrap();
        repeat (3) cycle();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
